// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue/writeback sequencer.
// The state enum values double as the fixed state encoding.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_issue_ctrl_booth.sv
// Combinational radix-4 Booth multiplier array, signed WIDTH x WIDTH -> 2*WIDTH.
// WIDTH must be even; each recoded digit consumes two multiplier bits.
module mul_issue_ctrl_booth #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG = WIDTH / 2;

    logic [WIDTH:0]     q_ext;
    logic [2*WIDTH-1:0] m_ext;
    logic [2*WIDTH-1:0] m_neg;
    logic [2*WIDTH-1:0] m_2x;
    logic [2*WIDTH-1:0] m_neg2x;
    logic [2*WIDTH-1:0] pp  [NDIG];
    logic [2*WIDTH-1:0] sum [NDIG+1];

    assign q_ext   = {q, 1'b0};
    assign m_ext   = {{WIDTH{m[WIDTH-1]}}, m};
    assign m_neg   = '0 - m_ext;
    assign m_2x    = m_ext << 1;
    assign m_neg2x = m_neg << 1;
    assign sum[0]  = '0;

    // Each digit looks at an overlapping bit triple and picks 0, +-M or +-2M.
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        logic [2:0]         digit;
        logic [2*WIDTH-1:0] sel;

        assign digit = q_ext[2*g+2 -: 3];

        always_comb begin
            sel = '0;
            case (digit)
                3'b001, 3'b010: sel = m_ext;
                3'b011:         sel = m_2x;
                3'b100:         sel = m_neg2x;
                3'b101, 3'b110: sel = m_neg;
                default:        sel = '0;
            endcase
        end

        assign pp[g]    = sel << (2 * g);
        assign sum[g+1] = sum[g] + pp[g];
    end

    assign product = sum[NDIG];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback sequencer: latches operands, lets the Booth array settle for
// SETTLE_CYCLES clocks (multicycle path), then captures the product into HI/LO.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH         = MUL_WIDTH,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    mul_state_t         state;
    mul_state_t         state_nxt;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               ovf_reg;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product;
    logic               accept;
    logic               zero_op;
    logic               settle_end;
    logic               product_ovf;

    // m_reg/q_reg are held for the whole SETTLE window; only their outputs are timed as multicycle.
    mul_issue_ctrl_booth #(
        .WIDTH (WIDTH)
    ) u_booth (
        .m       (m_reg),
        .q       (q_reg),
        .product (product)
    );

    assign start_ready = (state != SETTLE);
    assign busy        = (state == SETTLE);
    assign done        = (state == DONE);
    assign hi_out      = hi_reg;
    assign lo_out      = lo_reg;
    assign ovf         = ovf_reg;

    assign accept      = start_valid & start_ready & ~flush;
    assign zero_op     = (op_a == '0) || (op_b == '0);
    assign settle_end  = busy & ~flush & (cnt == '0);
    assign product_ovf = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush outranks everything except clear; DONE behaves like IDLE for acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = zero_op ? DONE : SETTLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETTLE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            m_reg   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            m_reg <= op_a;
            q_reg <= op_b;
            cnt   <= CNT_LOAD;
            if (zero_op) begin
                hi_reg  <= '0;
                lo_reg  <= '0;
                ovf_reg <= 1'b0;
            end
        end else if (settle_end) begin
            hi_reg  <= product[2*WIDTH-1:WIDTH];
            lo_reg  <= product[WIDTH-1:0];
            ovf_reg <= product_ovf;
        end else if (busy && !flush) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a cycle-level reference model.
module tb_mul_issue_ctrl;

    localparam int WIDTH         = 32;
    localparam int SETTLE_CYCLES = 3;

    logic             clock = 1'b0;
    logic             clear;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             ovf;

    int tests    = 0;
    int failures = 0;

    mul_issue_ctrl #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .ovf         (ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
        int          lat;
    } vec_t;

    // Reference model state: cycles left in flight and the pending result.
    int          rem;
    logic [64:0] pend;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_ovf;
    logic        m_done;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] a, input logic [31:0] b,
                                 input logic fl);
        start_valid = sv;
        op_a        = a;
        op_b        = b;
        flush       = fl;
    endtask

    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Waits for start_ready, presents one request for exactly one edge.
    task automatic issueOp(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("issue_ready", 72'(start_ready), 72'(1));
        applyStimulus(1'b1, a, b, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Called one step after the accept edge; lat=1 means done is already high.
    task automatic waitDone(input int budget, output int lat, output bit seen);
        lat = 1;
        while (!done && lat <= budget) begin
            tick();
            lat++;
        end
        seen = done;
    endtask

    function automatic logic [64:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic   o;
        p = longint'($signed(a)) * longint'($signed(b));
        o = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return {o, p};
    endfunction

    task automatic modelStep(input logic sv, input logic [31:0] a, input logic [31:0] b,
                             input logic fl);
        m_done = 1'b0;
        if (rem > 0) begin
            if (fl) begin
                rem = 0;
            end else begin
                rem--;
                if (rem == 0) begin
                    {m_ovf, m_hi, m_lo} = pend;
                    m_done = 1'b1;
                end
            end
        end else if (sv && !fl) begin
            if (a == 0 || b == 0) begin
                m_hi   = '0;
                m_lo   = '0;
                m_ovf  = 1'b0;
                m_done = 1'b1;
            end else begin
                pend = refProduct(a, b);
                rem  = SETTLE_CYCLES;
            end
        end
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t vecs[10];
        int   lat;
        bit   seen;
        int   done_cnt;
        logic sv, fl;
        logic [31:0] a, b;

        // 12345*10000 = 123450000 = 0x075BB290
        vecs[0] = '{32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 4};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 4};
        vecs[2] = '{32'd12345,     32'd10000,     32'h0000_0000, 32'h075B_B290, 1'b0, 4};
        vecs[3] = '{32'h0,         32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 4};
        vecs[5] = '{32'h7FFF_FFFF, 32'd2,         32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 4};
        vecs[6] = '{32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 4};
        vecs[7] = '{32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 4};
        vecs[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1, 4};
        vecs[9] = '{32'h1234_5678, 32'h0,         32'h0000_0000, 32'h0000_0000, 1'b0, 1};

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        clear = 1'b1;
        #12;
        checkOutput("reset_ready", 72'(start_ready), 72'(1));
        checkOutput("reset_busy",  72'(busy),        72'(0));
        checkOutput("reset_done",  72'(done),        72'(0));
        checkOutput("reset_hilo",  {8'h0, hi_out, lo_out}, 72'(0));
        checkOutput("reset_ovf",   72'(ovf),         72'(0));
        tick();
        clear = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            issueOp(vecs[i].a, vecs[i].b);
            waitDone(20, lat, seen);
            checkOutput($sformatf("vec%0d_done", i), 72'(seen), 72'(1));
            checkOutput($sformatf("vec%0d_lat", i), 72'(lat), 72'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_hi", i), 72'(hi_out), 72'(vecs[i].hi));
            checkOutput($sformatf("vec%0d_lo", i), 72'(lo_out), 72'(vecs[i].lo));
            checkOutput($sformatf("vec%0d_ovf", i), 72'(ovf), 72'(vecs[i].ovf));
            tick();
            checkOutput($sformatf("vec%0d_pulse", i), 72'(done), 72'(0));
        end

        // Flush two edges after accept: no done, old result kept.
        issueOp(32'd7, 32'hFFFF_FFFD);
        waitDone(20, lat, seen);
        tick();
        issueOp(32'd5, 32'd5);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("flush_ready", 72'(start_ready), 72'(1));
        checkOutput("flush_busy",  72'(busy),        72'(0));
        checkOutput("flush_hilo",  {8'h0, hi_out, lo_out}, {8'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            tick();
        end
        checkOutput("flush_no_done", 72'(done_cnt), 72'(0));

        // Back-to-back issue in the DONE cycle.
        issueOp(32'd2, 32'd3);
        waitDone(20, lat, seen);
        checkOutput("b2b_first_lo", 72'(lo_out), 72'(6));
        applyStimulus(1'b1, 32'd4, 32'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("b2b_busy", 72'(busy), 72'(1));
        waitDone(20, lat, seen);
        checkOutput("b2b_spacing", 72'(lat), 72'(4));
        checkOutput("b2b_second", {8'h0, hi_out, lo_out}, 72'(20));
        tick();

        // Request held while busy is ignored until the DONE cycle.
        issueOp(32'd6, 32'd7);
        applyStimulus(1'b1, 32'd9, 32'd9, 1'b0);
        lat = 0;
        while (!done && lat < 10) begin
            checkOutput("held_ready_low", 72'(start_ready), 72'(0));
            tick();
            lat++;
        end
        checkOutput("held_first_done", 72'(done), 72'(1));
        checkOutput("held_first_lo", 72'(lo_out), 72'(42));
        checkOutput("held_ready_done", 72'(start_ready), 72'(1));
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("held_accepted", 72'(busy), 72'(1));
        waitDone(20, lat, seen);
        checkOutput("held_second_lat", 72'(lat), 72'(4));
        checkOutput("held_second_lo", 72'(lo_out), 72'(81));
        tick();

        // Asynchronous clear between edges while in SETTLE.
        issueOp(32'd3, 32'd4);
        tick();
        #2;
        clear = 1'b1;
        #1;
        checkOutput("clr_async", {start_ready, busy, done, ovf, 4'h0, hi_out, lo_out},
                    {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0});
        #1;
        clear = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_cnt++;
        end
        checkOutput("clr_no_done", 72'(done_cnt), 72'(0));

        // Random traffic against the reference model.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rem = 0; pend = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            sv = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 9) == 0);
            a  = randOperand();
            b  = randOperand();
            applyStimulus(sv, a, b, fl);
            modelStep(sv, a, b, fl);
            tick();
            checkOutput($sformatf("rand%0d", i),
                        {start_ready, busy, done, ovf, 4'h0, hi_out, lo_out},
                        {(rem == 0), (rem > 0), m_done, m_ovf, 4'h0, m_hi, m_lo});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
